// File: rtl/blockade_pkg.sv
// blockade_pkg: shared types and constants for the blockade ROM download path
package blockade_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;
  localparam int ROM_AW = 14;
  localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
endpackage

// File: rtl/blockade_dl_buf.sv
// blockade_dl_buf: one-byte capture buffer that issues a ROM write and paces the next one
module blockade_dl_buf
  import blockade_pkg::*;
#(
  parameter int ROM_SIZE = 16384,
  parameter int WR_GAP   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cap_i,
  input  logic [24:0]       addr_i,
  input  logic [7:0]        data_i,
  output logic              full_o,
  output logic              wr_o,
  output logic              oor_o,
  output logic [ROM_AW-1:0] addr_o,
  output logic [7:0]        data_o
);
  logic              full_q, full_d, wr_q, wr_d, oor_q, oor_d, in_range, free;
  logic [3:0]        gap_q, gap_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  assign in_range = addr_i < 25'(ROM_SIZE);
  // The write cycle plus WR_GAP idle cycles occupy the buffer; release on the last of them.
  assign free = full_q & (oor_q | (wr_q ? gap_q == 4'd0 : gap_q == 4'd1));
  // Next-state: capture launches the write immediately, then the gap counter drains.
  always_comb begin
    full_d = cap_i ? 1'b1 : full_q & ~free;
    wr_d   = cap_i & in_range;
    oor_d  = cap_i & ~in_range;
    gap_d  = cap_i ? 4'(WR_GAP) : (full_q & ~wr_q & gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
    addr_d = (cap_i & in_range) ? addr_i[ROM_AW-1:0] : addr_q;
    data_d = (cap_i & in_range) ? data_i : data_q;
  end
  // Buffer registers; reset drops any pending byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      wr_q   <= 1'b0;
      oor_q  <= 1'b0;
      gap_q  <= 4'd0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      wr_q   <= wr_d;
      oor_q  <= oor_d;
      gap_q  <= gap_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign full_o = full_q;
  assign wr_o   = wr_q;
  assign oor_o  = oor_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
endmodule

// File: rtl/blockade_dl_ctrl.sv
// blockade_dl_ctrl: sequences ioctl ROM downloads into the blockade core and owns its reset
module blockade_dl_ctrl
  import blockade_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX   = ROM_INDEX_DEF,
  parameter int         ROM_SIZE    = 16384,
  parameter int         WR_GAP      = 2,
  parameter int         HOLD_CYCLES = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset,
  output logic              dl_done,
  output logic              dl_err,
  output logic [14:0]       byte_count,
  output logic [7:0]        checksum
);
  state_t      state_q;
  logic        active, active_q, cap, ovf, full, wr, oor, core_reset_q, done_q, err_q;
  logic [9:0]  hold_q;
  logic [14:0] count_q;
  logic [7:0]  sum_q;
  assign active = ioctl_download && ioctl_index == ROM_INDEX;
  assign cap    = state_q == LOAD && active && ioctl_wr && !full;
  assign ovf    = state_q == LOAD && active && ioctl_wr && full;
  blockade_dl_buf #(.ROM_SIZE(ROM_SIZE), .WR_GAP(WR_GAP)) u_buf (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .cap_i  (cap),
    .addr_i (ioctl_addr),
    .data_i (ioctl_dout),
    .full_o (full),
    .wr_o   (wr),
    .oor_o  (oor),
    .addr_o (dn_addr),
    .data_o (dn_data)
  );
  // Download FSM with hold-off counter, statistics and registered core reset/status.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      active_q     <= 1'b0;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      sum_q        <= '0;
    end else begin
      active_q <= active;
      if (wr) begin
        count_q <= count_q + {14'd0, count_q != '1};
        sum_q   <= sum_q + dn_data;
      end
      if (oor || ovf) err_q <= 1'b1;
      case (state_q)
        IDLE, RUN: if (active && (state_q == IDLE || !active_q)) begin
          state_q      <= LOAD;
          core_reset_q <= 1'b1;
          count_q      <= '0;
          sum_q        <= '0;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
        end
        LOAD: if (!active && !full) begin
          state_q <= HOLD;
          hold_q  <= 10'(HOLD_CYCLES - 1);
        end
        HOLD: if (hold_q == '0) begin
          state_q      <= RUN;
          core_reset_q <= 1'b0;
          done_q       <= 1'b1;
        end else hold_q <= hold_q - 10'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ioctl_wait = full;
  assign dn_wr      = wr;
  assign core_reset = core_reset_q;
  assign dl_done    = done_q;
  assign dl_err     = err_q;
  assign byte_count = count_q;
  assign checksum   = sum_q;
endmodule

// File: tb/tb_blockade_dl_ctrl.sv
// tb_blockade_dl_ctrl: scoreboard bench for the blockade ROM download sequencer
module tb_blockade_dl_ctrl;
  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0, ioctl_index = '0;
  logic        ioctl_wait, dn_wr, core_reset, dl_done, dl_err;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data, checksum;
  logic [14:0] byte_count;
  typedef struct {int c; logic [13:0] a; logic [7:0] d;} exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, total = 0, bad = 0, n;

  blockade_dl_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .core_reset(core_reset), .dl_done(dl_done), .dl_err(dl_err),
    .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) if (dn_wr) begin
    if (sb.size() == 0) chk("unexpected_wr", {18'd0, dn_addr}, 32'hFFFF_FFFF);
    else begin
      e = sb.pop_front();
      chk("wr_cycle", cyc, e.c);
      chk("wr_addr", dn_addr, e.a);
      chk("wr_data", dn_data, e.d);
    end
  end

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit push, input bit ew);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (push) sb.push_back('{cyc + 1, a[13:0], d});
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("wait_after_strobe", ioctl_wait, ew);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_wait"}, ioctl_wait, 0);
    chk({tag, "_dn_wr"}, dn_wr, 0);
    chk({tag, "_dn_addr"}, dn_addr, 0);
    chk({tag, "_dn_data"}, dn_data, 0);
    chk({tag, "_done"}, dl_done, 0);
    chk({tag, "_err"}, dl_err, 0);
    chk({tag, "_count"}, byte_count, 0);
    chk({tag, "_sum"}, checksum, 0);
  endtask

  task automatic wait_run(input int from, input int exp_len, input string tag);
    for (int i = 0; i < 300 && core_reset; i++) @(negedge clk_sys);
    chk(tag, cyc - from, exp_len);
    chk({tag, "_done"}, dl_done, 1);
  endtask

  initial begin
    logic [7:0] bytes [4] = '{8'hA5, 8'h01, 8'hFF, 8'h10};
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk_sys);
    @(negedge clk_sys);
    check_idle("rst");
    @(posedge clk_sys); #1 ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(25'(i), bytes[i], 1, 1);
      if (i < 3) repeat (2) @(posedge clk_sys);
    end
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("dl1_count", byte_count, 4);
    chk("dl1_sum", checksum, 8'hB5);
    chk("dl1_err", dl_err, 0);
    chk("dl1_core_reset", core_reset, 1);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = 25'd4; ioctl_dout = 8'h22;
    sb.push_back('{cyc + 1, 14'd4, 8'h22});
    @(posedge clk_sys); #1;
    ioctl_addr = 25'd5; ioctl_dout = 8'h33;
    @(negedge clk_sys);
    chk("b2b_wait", ioctl_wait, 1);
    @(posedge clk_sys); #1 ioctl_wr = 1'b0;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("b2b_err", dl_err, 1);
    chk("b2b_count", byte_count, 5);
    chk("b2b_sum", checksum, 8'hD7);
    @(posedge clk_sys); #1 ioctl_download = 1'b0;
    n = cyc;
    wait_run(n, 65, "hold1_len");
    chk("hold1_core_reset", core_reset, 0);
    @(posedge clk_sys); #1 ioctl_download = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("dl2_core_reset", core_reset, 1);
    chk("dl2_done", dl_done, 0);
    chk("dl2_err", dl_err, 0);
    chk("dl2_count", byte_count, 0);
    strobe(25'd16384, 8'h77, 0, 1);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("oor_err", dl_err, 1);
    chk("oor_count", byte_count, 0);
    chk("oor_sum", checksum, 0);
    strobe(25'd1, 8'h5A, 1, 1);
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("dl2_count_after", byte_count, 1);
    chk("dl2_sum_after", checksum, 8'h5A);
    @(posedge clk_sys); #1 ioctl_download = 1'b0;
    n = cyc;
    wait_run(n, 65, "hold2_len");
    @(posedge clk_sys); #1 ioctl_index = 8'd1; ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) strobe(25'(i), 8'hC0 + 8'(i), 0, 0);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("idx1_core_reset", core_reset, 0);
    chk("idx1_count", byte_count, 1);
    @(posedge clk_sys); #1 ioctl_download = 1'b0; ioctl_index = 8'd0;
    @(posedge clk_sys); #1 ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    strobe(25'd7, 8'h3C, 1, 1);
    @(posedge clk_sys); #1;
    chk("pend_wait_before", ioctl_wait, 1);
    reset = 1'b1;
    #1;
    check_idle("async_rst");
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    ioctl_download = 1'b0;
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    check_idle("post_rst");
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
